// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings, direction codes and rally event flags
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // Ball-overlap events seen during one frame of play.
  typedef struct packed {
    logic miss_r;
    logic miss_l;
    logic bot;
    logic top;
    logic hit_p1;
    logic hit_p0;
  } events_t;

endpackage

// File: rtl/pong_event_latch.sv
// rtl/pong_event_latch.sv - sticky per-frame event flags, cleared on the frame strobe
module pong_event_latch
  import pong_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  events_t set,
  input  logic    clear,
  output events_t flags
);

  // An event coincident with the clear belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (clear) begin
      flags <= set;
    end else begin
      flags <= events_t'(flags | set);
    end
  end

endmodule

// File: rtl/pong_rally_ctrl.sv
// rtl/pong_rally_ctrl.sv - serve/play/game-over FSM with bounce, miss and score handling
module pong_rally_ctrl
  import pong_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_N,
  input  logic                 i_VReset,
  input  logic                 i_HFirst,
  input  logic                 i_HLast,
  input  logic                 i_VFirst,
  input  logic                 i_VLast,
  input  logic                 i_Ball,
  input  logic [N_PLAYERS-1:0] i_Paddle,
  input  logic                 i_Start,
  output logic                 o_XDir,
  output logic                 o_YDir,
  output logic                 o_Ball_En,
  output logic                 o_Ball_Reset,
  output logic [SCORE_W-1:0]   o_Score0,
  output logic [SCORE_W-1:0]   o_Score1,
  output logic [1:0]           o_State,
  output logic                 o_Winner
);

  localparam int CNT_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;

  if (N_PLAYERS < 1 || N_PLAYERS > 2) begin : g_bad_players
    $error("pong_rally_ctrl: N_PLAYERS must be 1 or 2");
  end
  if (WIN_SCORE == 0 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win
    $error("pong_rally_ctrl: WIN_SCORE must be in 1 .. 2**SCORE_W-1");
  end

  state_t             state, state_n;
  logic               x_dir, x_dir_n, y_dir, y_dir_n;
  logic               ball_en, ball_reset, ball_reset_n;
  logic               winner, winner_n;
  logic [SCORE_W-1:0] score0, score0_n, score1, score1_n, new_score;
  logic [CNT_W-1:0]   serve_cnt, serve_cnt_n;
  logic [1:0]         paddle;
  logic               scored, scorer, serve_dir;
  events_t            set_ev, flags;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(WIN_SCORE)) ? s : s + SCORE_W'(1);
  endfunction

  // Single-player builds see a permanently idle right paddle.
  assign paddle = 2'(i_Paddle);

  always_comb begin
    set_ev = '0;
    if (state == ST_PLAY && i_Ball) begin
      set_ev.hit_p0 = paddle[0];
      set_ev.hit_p1 = paddle[1];
      set_ev.top    = i_VFirst;
      set_ev.bot    = i_VLast;
      set_ev.miss_l = i_HFirst;
      set_ev.miss_r = i_HLast;
    end
  end

  pong_event_latch u_events (
    .clk   (i_Clk),
    .rst_n (i_Reset_N),
    .set   (set_ev),
    .clear (i_VReset),
    .flags (flags)
  );

  always_comb begin
    state_n      = state;
    x_dir_n      = x_dir;
    y_dir_n      = y_dir;
    score0_n     = score0;
    score1_n     = score1;
    winner_n     = winner;
    serve_cnt_n  = serve_cnt;
    ball_reset_n = 1'b0;
    scored       = 1'b0;
    scorer       = 1'b0;
    serve_dir    = DIR_LEFT;
    new_score    = '0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (i_Start) begin
          state_n      = ST_SERVE;
          score0_n     = '0;
          score1_n     = '0;
          x_dir_n      = DIR_LEFT;
          y_dir_n      = DIR_DOWN;
          serve_cnt_n  = '0;
          ball_reset_n = 1'b1;
        end
      end
      ST_SERVE: begin
        if (i_VReset) begin
          if (serve_cnt == CNT_W'(SERVE_FRAMES)) begin
            state_n     = ST_PLAY;
            serve_cnt_n = '0;
          end else begin
            serve_cnt_n = serve_cnt + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (i_VReset) begin
          // A miss outranks any paddle contact in the same frame.
          if (flags.miss_l) begin
            scored    = 1'b1;
            serve_dir = DIR_LEFT;
            if (N_PLAYERS == 2) begin
              scorer    = 1'b1;
              new_score = sat_inc(score1);
              score1_n  = new_score;
            end else begin
              new_score = sat_inc(score0);
              score0_n  = new_score;
            end
          end else if (flags.miss_r && N_PLAYERS == 2) begin
            scored    = 1'b1;
            serve_dir = DIR_RIGHT;
            new_score = sat_inc(score0);
            score0_n  = new_score;
          end else if (flags.hit_p0) begin
            x_dir_n = DIR_RIGHT;
          end else if (flags.hit_p1 || flags.miss_r) begin
            x_dir_n = DIR_LEFT;
          end
          if (flags.top) begin
            y_dir_n = DIR_DOWN;
          end else if (flags.bot) begin
            y_dir_n = DIR_UP;
          end
          if (scored) begin
            if (new_score == SCORE_W'(WIN_SCORE)) begin
              state_n  = ST_OVER;
              winner_n = scorer;
            end else begin
              state_n      = ST_SERVE;
              x_dir_n      = serve_dir;
              ball_reset_n = 1'b1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state      <= ST_IDLE;
      x_dir      <= DIR_LEFT;
      y_dir      <= DIR_DOWN;
      ball_en    <= 1'b0;
      ball_reset <= 1'b0;
      score0     <= '0;
      score1     <= '0;
      winner     <= 1'b0;
      serve_cnt  <= '0;
    end else begin
      state      <= state_n;
      x_dir      <= x_dir_n;
      y_dir      <= y_dir_n;
      ball_en    <= (state_n == ST_PLAY);
      ball_reset <= ball_reset_n;
      score0     <= score0_n;
      score1     <= score1_n;
      winner     <= winner_n;
      serve_cnt  <= serve_cnt_n;
    end
  end

  assign o_XDir       = x_dir;
  assign o_YDir       = y_dir;
  assign o_Ball_En    = ball_en;
  assign o_Ball_Reset = ball_reset;
  assign o_Score0     = score0;
  assign o_Score1     = (N_PLAYERS == 2) ? score1 : '0;
  assign o_State      = state;
  assign o_Winner     = winner;

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// tb/tb_pong_rally_ctrl.sv - two-player and one-player rally controllers against a frame-level model
module tb_pong_rally_ctrl;

  localparam int HIT0 = 0, HIT1 = 1, TOP = 2, BOT = 3, MISSL = 4, MISSR = 5;

  logic       clk = 1'b0;
  logic       rst_n, vreset, hfirst, hlast, vfirst, vlast, ball, start;
  logic [1:0] paddle;

  logic       a_x, a_y, a_en, a_br, a_win, b_x, b_y, b_en, b_br, b_win;
  logic [3:0] a_s0, a_s1, b_s0, b_s1;
  logic [1:0] a_st, b_st;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance 0: two players, short game; instance 1: solo play, instant serve.
  int m_np [2] = '{2, 1};
  int m_win_score [2] = '{3, 5};
  int m_sf [2] = '{2, 0};

  int m_state [2];
  int m_frames [2];
  int m_score [2][2];
  bit m_x [2], m_y [2], m_en [2], m_br [2], m_winner [2];
  bit m_seen [2][6];

  always #5 clk = ~clk;

  pong_rally_ctrl #(.N_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(2)) dut_a (
    .i_Clk(clk), .i_Reset_N(rst_n), .i_VReset(vreset), .i_HFirst(hfirst), .i_HLast(hlast),
    .i_VFirst(vfirst), .i_VLast(vlast), .i_Ball(ball), .i_Paddle(paddle), .i_Start(start),
    .o_XDir(a_x), .o_YDir(a_y), .o_Ball_En(a_en), .o_Ball_Reset(a_br),
    .o_Score0(a_s0), .o_Score1(a_s1), .o_State(a_st), .o_Winner(a_win)
  );

  pong_rally_ctrl #(.N_PLAYERS(1), .SCORE_W(4), .WIN_SCORE(5), .SERVE_FRAMES(0)) dut_b (
    .i_Clk(clk), .i_Reset_N(rst_n), .i_VReset(vreset), .i_HFirst(hfirst), .i_HLast(hlast),
    .i_VFirst(vfirst), .i_VLast(vlast), .i_Ball(ball), .i_Paddle(paddle[0]), .i_Start(start),
    .o_XDir(b_x), .o_YDir(b_y), .o_Ball_En(b_en), .o_Ball_Reset(b_br),
    .o_Score0(b_s0), .o_Score1(b_s1), .o_State(b_st), .o_Winner(b_win)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_frames[k] = 0; m_x[k] = 0; m_y[k] = 1;
      m_en[k] = 0; m_br[k] = 0; m_winner[k] = 0;
      m_score[k][0] = 0; m_score[k][1] = 0;
      for (int e = 0; e < 6; e++) m_seen[k][e] = 0;
    end
  endtask

  task automatic begin_serve(input int k);
    m_state[k] = 1; m_frames[k] = 0; m_br[k] = 1;
    m_score[k][0] = 0; m_score[k][1] = 0; m_x[k] = 0; m_y[k] = 1;
  endtask

  task automatic end_of_frame(input int k);
    int who = -1;
    bit serve_right = 0;
    if (m_seen[k][MISSL]) who = (m_np[k] == 2) ? 1 : 0;
    else if (m_seen[k][MISSR] && m_np[k] == 2) begin who = 0; serve_right = 1; end
    else if (m_seen[k][HIT0]) m_x[k] = 1;
    else if (m_seen[k][HIT1] || (m_seen[k][MISSR] && m_np[k] == 1)) m_x[k] = 0;
    if (m_seen[k][TOP]) m_y[k] = 1;
    else if (m_seen[k][BOT]) m_y[k] = 0;
    if (who >= 0) begin
      if (m_score[k][who] < m_win_score[k]) m_score[k][who]++;
      if (m_score[k][who] == m_win_score[k]) begin
        m_state[k] = 3; m_winner[k] = who[0];
      end else begin
        m_state[k] = 1; m_frames[k] = 0; m_br[k] = 1; m_x[k] = serve_right;
      end
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit now [6];
      bit live = (m_state[k] == 2) && ball;
      now[HIT0]  = live && paddle[0];
      now[HIT1]  = live && m_np[k] == 2 && paddle[1];
      now[TOP]   = live && vfirst;
      now[BOT]   = live && vlast;
      now[MISSL] = live && hfirst;
      now[MISSR] = live && hlast;
      m_br[k] = 0;
      case (m_state[k])
        0, 3: if (start) begin_serve(k);
        1: if (vreset) begin
          if (m_frames[k] == m_sf[k]) begin m_state[k] = 2; m_frames[k] = 0; end
          else m_frames[k]++;
        end
        2: if (vreset) end_of_frame(k);
        default: ;
      endcase
      for (int e = 0; e < 6; e++) m_seen[k][e] = vreset ? now[e] : (m_seen[k][e] | now[e]);
      m_en[k] = (m_state[k] == 2);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_state"}, a_st, m_state[0]);
    chk({tag, ".a_xdir"}, a_x, m_x[0]);
    chk({tag, ".a_ydir"}, a_y, m_y[0]);
    chk({tag, ".a_ball_en"}, a_en, m_en[0]);
    chk({tag, ".a_ball_reset"}, a_br, m_br[0]);
    chk({tag, ".a_score0"}, a_s0, m_score[0][0]);
    chk({tag, ".a_score1"}, a_s1, m_score[0][1]);
    if (m_state[0] == 3) chk({tag, ".a_winner"}, a_win, m_winner[0]);
    chk({tag, ".b_state"}, b_st, m_state[1]);
    chk({tag, ".b_xdir"}, b_x, m_x[1]);
    chk({tag, ".b_ydir"}, b_y, m_y[1]);
    chk({tag, ".b_ball_en"}, b_en, m_en[1]);
    chk({tag, ".b_ball_reset"}, b_br, m_br[1]);
    chk({tag, ".b_score0"}, b_s0, m_score[1][0]);
    chk({tag, ".b_score1"}, b_s1, m_score[1][1]);
    if (m_state[1] == 3) chk({tag, ".b_winner"}, b_win, m_winner[1]);
  endtask

  task automatic clear_inputs();
    vreset = 0; hfirst = 0; hlast = 0; vfirst = 0; vlast = 0; ball = 0; paddle = 2'b00; start = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
    check_all("cyc");
  endtask

  // Event bit i is presented with the ball on frame cycle 2+i.
  task automatic run_frame(input int len, input bit [5:0] ev, input bit start_at_vreset);
    for (int c = 0; c < len; c++) begin
      clear_inputs();
      vreset = (c == 0);
      start  = (c == 0) && start_at_vreset;
      if (c >= 2 && c < 8 && ev[c-2]) begin
        ball = 1;
        case (c - 2)
          HIT0:    paddle[0] = 1;
          HIT1:    paddle[1] = 1;
          TOP:     vfirst = 1;
          BOT:     vlast = 1;
          MISSL:   hfirst = 1;
          default: hlast = 1;
        endcase
      end
      step();
    end
  endtask

  task automatic rand_frame();
    int len = $urandom_range(6, 20);
    for (int c = 0; c < len; c++) begin
      vreset = (c == 0);
      ball   = ($urandom_range(0, 2) == 0);
      paddle = 2'($urandom_range(0, 3));
      hfirst = ($urandom_range(0, 9) == 0);
      hlast  = ($urandom_range(0, 9) == 0);
      vfirst = ($urandom_range(0, 5) == 0);
      vlast  = ($urandom_range(0, 5) == 0);
      start  = ($urandom_range(0, 30) == 0);
      step();
    end
  endtask

  // Called just after a checked edge, so reset moves away from any clock edge.
  task automatic async_reset(input string tag);
    rst_n = 0;
    model_reset();
    #1;
    check_all(tag);
    clear_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    step();
    step();
    chk("reset.state", a_st, 0);
    chk("reset.ydir", a_y, 1);
    chk("reset.score0", a_s0, 0);
    rst_n = 1;

    run_frame(10, 6'h00, 0);
    run_frame(10, 6'h3f, 0);
    chk("idle_no_start.state", a_st, 0);

    start = 1;
    step();
    chk("start.ball_reset", a_br, 1);
    chk("start.state", a_st, 1);
    clear_inputs();
    step();
    chk("start.ball_reset_width", a_br, 0);

    run_frame(12, 6'h00, 0);
    run_frame(12, 6'h00, 0);
    chk("serve_2frames.state", a_st, 1);
    run_frame(12, 6'h00, 0);
    chk("play.state", a_st, 2);
    chk("play.ball_en", a_en, 1);
    chk("play.xdir", a_x, 0);
    chk("play.ydir", a_y, 1);

    run_frame(12, (6'b1 << HIT0) | (6'b1 << TOP), 0);
    chk("hit0.xdir_pending", a_x, 0);
    run_frame(12, 6'h00, 0);
    chk("hit0.xdir", a_x, 1);
    chk("top.ydir", a_y, 1);
    run_frame(12, 6'b1 << BOT, 0);
    run_frame(12, 6'h00, 0);
    chk("bot.ydir", a_y, 0);

    run_frame(12, (6'b1 << MISSL) | (6'b1 << HIT0), 0);
    run_frame(12, 6'h00, 0);
    chk("missl.score1", a_s1, 1);
    chk("missl.score0", a_s0, 0);
    chk("missl.state", a_st, 1);
    chk("missl.xdir", a_x, 0);
    chk("solo_missl.score0", b_s0, 1);
    run_frame(12, 6'h00, 0);
    run_frame(12, 6'h00, 0);

    for (int i = 0; i < 3; i++) begin
      run_frame(12, 6'b1 << MISSR, 0);
      run_frame(12, 6'h00, 0);
      chk("missr.score0", a_s0, i + 1);
      chk("solo_missr.xdir", b_x, 0);
      chk("solo_missr.score1", b_s1, 0);
      if (i < 2) begin
        chk("missr.serve_xdir", a_x, 1);
        run_frame(12, 6'h00, 0);
        run_frame(12, 6'h00, 0);
      end
    end
    chk("over.state", a_st, 3);
    chk("over.winner", a_win, 0);
    chk("over.score0", a_s0, 3);
    chk("over.ball_en", a_en, 0);
    run_frame(12, (6'b1 << MISSR) | (6'b1 << MISSL), 0);
    run_frame(12, 6'b1 << MISSR, 0);
    chk("over.saturate", a_s0, 3);

    run_frame(12, 6'h00, 1);
    chk("restart.state", a_st, 1);
    chk("restart.score0", a_s0, 0);
    chk("restart.score1", a_s1, 0);
    run_frame(12, 6'h00, 0);
    async_reset("rst_mid_serve");
    chk("rst_mid_serve.state", a_st, 0);
    chk("rst_mid_serve.ball_en", a_en, 0);
    run_frame(12, 6'h3f, 0);
    run_frame(12, 6'h00, 0);
    chk("post_reset.idle", a_st, 0);

    for (int f = 0; f < 400; f++) begin
      rand_frame();
      if ($urandom_range(0, 60) == 0) async_reset("rst_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
